// File: rtl/emmc_ddr_dat_sequencer.sv
// eMMC DAT-line DDR sequencer: frames one data block (start bit, data, per-line CRC16s,
// end bit) to or from the card, including the write CRC-status token and busy phase.
module emmc_ddr_dat_sequencer #(
  parameter int W           = 4,
  parameter int BLOCK_BYTES = 512,
  parameter int TOUT_W      = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_start,
  input  logic              rd_start,
  input  logic              abort,
  input  logic [TOUT_W-1:0] rd_tout,
  input  logic [TOUT_W-1:0] busy_tout,
  output logic              seq_busy,
  output logic              done,
  output logic [2:0]        status,
  input  logic [2*W-1:0]    tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [2*W-1:0]    rx_data,
  output logic              rx_valid,
  output logic [W-1:0]      dat_wr_pos,
  output logic [W-1:0]      dat_wr_neg,
  output logic              dat_oe,
  input  logic [W-1:0]      dat_rd_pos,
  input  logic [W-1:0]      dat_rd_neg
);

  localparam int DCYC = BLOCK_BYTES * 8 / (2 * W);
  localparam int BW   = (DCYC > 16) ? $clog2(DCYC) : 4;

  localparam logic [BW-1:0]     DATA_LAST = BW'(DCYC - 1);
  localparam logic [BW-1:0]     CRC_LAST  = BW'(15);
  localparam logic [BW-1:0]     BIT_ONE   = BW'(1);
  localparam logic [TOUT_W-1:0] TOUT_ONE  = TOUT_W'(1);
  localparam logic [TOUT_W:0]   TOUT_ONEX = (TOUT_W + 1)'(1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] W_START = 4'd1;
  localparam logic [3:0] W_DATA  = 4'd2;
  localparam logic [3:0] W_CRC   = 4'd3;
  localparam logic [3:0] W_END   = 4'd4;
  localparam logic [3:0] W_TOK   = 4'd5;
  localparam logic [3:0] W_BUSY  = 4'd6;
  localparam logic [3:0] R_WAIT  = 4'd7;
  localparam logic [3:0] R_DATA  = 4'd8;
  localparam logic [3:0] R_CRC   = 4'd9;
  localparam logic [3:0] R_END   = 4'd10;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_CRC_ERR  = 3'd1;
  localparam logic [2:0] ST_END_ERR  = 3'd2;
  localparam logic [2:0] ST_TIMEOUT  = 3'd3;
  localparam logic [2:0] ST_CRC_NAK  = 3'd4;
  localparam logic [2:0] ST_UNDERRUN = 3'd5;
  localparam logic [2:0] ST_ABORTED  = 3'd6;

  logic [3:0]        state, stateNxt;
  logic [BW-1:0]     bitCnt;
  logic [TOUT_W-1:0] toutCnt, toutLimit;
  logic              toutHit;
  logic [2:0]        tokCnt, tokBits;
  logic [15:0]       crcPos [W];
  logic [15:0]       crcNeg [W];
  logic [3:0]        crcIdx;
  logic              crcErr, crcMiss;
  logic              finish, startAcc;
  logic [2:0]        finStatus;

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign crcIdx    = 4'd15 - bitCnt[3:0];
  assign toutLimit = (state == R_WAIT) ? rd_tout : busy_tout;
  assign toutHit   = ({1'b0, toutCnt} + TOUT_ONEX) >= {1'b0, toutLimit};
  assign startAcc  = (state == IDLE) && (stateNxt != IDLE);
  assign seq_busy  = (state != IDLE);
  assign tx_ready  = (state == W_DATA) && tx_valid && !abort;

  // NOTE: every variable an always_comb writes gets a default first, so no path can infer a latch.
  always_comb begin
    stateNxt  = state;
    finish    = 1'b0;
    finStatus = ST_OK;
    if (state != IDLE && abort) begin
      finish    = 1'b1;
      finStatus = ST_ABORTED;
    end else begin
      case (state)
        IDLE: begin
          if (!abort && wr_start)      stateNxt = W_START;
          else if (!abort && rd_start) stateNxt = R_WAIT;
        end
        W_START: stateNxt = W_DATA;
        W_DATA: begin
          if (!tx_valid) begin
            finish    = 1'b1;
            finStatus = ST_UNDERRUN;
          end else if (bitCnt == DATA_LAST) begin
            stateNxt = W_CRC;
          end
        end
        W_CRC:  if (bitCnt == CRC_LAST) stateNxt = W_END;
        W_END:  stateNxt = W_TOK;
        W_TOK: begin
          // tokCnt == 4 marks the end-bit slot; the three token bits are already in tokBits
          if (tokCnt == 3'd4) begin
            if (tokBits == 3'b010) stateNxt = W_BUSY;
            else begin
              finish    = 1'b1;
              finStatus = ST_CRC_NAK;
            end
          end else if (toutHit) begin
            finish    = 1'b1;
            finStatus = ST_TIMEOUT;
          end
        end
        W_BUSY: begin
          if (dat_rd_pos[0]) begin
            finish = 1'b1;
          end else if (toutHit) begin
            finish    = 1'b1;
            finStatus = ST_TIMEOUT;
          end
        end
        R_WAIT: begin
          if (dat_rd_pos == '0) stateNxt = R_DATA;
          else if (toutHit) begin
            finish    = 1'b1;
            finStatus = ST_TIMEOUT;
          end
        end
        R_DATA: if (bitCnt == DATA_LAST) stateNxt = R_CRC;
        R_CRC:  if (bitCnt == CRC_LAST) stateNxt = R_END;
        R_END: begin
          finish    = 1'b1;
          finStatus = (dat_rd_pos != '1) ? ST_END_ERR : (crcErr ? ST_CRC_ERR : ST_OK);
        end
        default: stateNxt = IDLE;
      endcase
    end
    if (finish) stateNxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      toutCnt  <= '0;
      tokCnt   <= '0;
      tokBits  <= '0;
      done     <= 1'b0;
      status   <= ST_OK;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state <= stateNxt;
      done  <= finish;
      if (finish)        status <= finStatus;
      else if (startAcc) status <= ST_OK;

      if (stateNxt != state) bitCnt <= '0;
      else                   bitCnt <= bitCnt + BIT_ONE;

      // the busy budget spans token and busy phases, so W_TOK -> W_BUSY keeps counting
      if (stateNxt != state && !(state == W_TOK && stateNxt == W_BUSY)) toutCnt <= '0;
      else if (toutCnt != '1)                                           toutCnt <= toutCnt + TOUT_ONE;

      if (state != W_TOK) begin
        tokCnt <= '0;
      end else if (tokCnt == 3'd0) begin
        if (!dat_rd_pos[0]) tokCnt <= 3'd1;
      end else if (tokCnt != 3'd4) begin
        tokBits <= {tokBits[1:0], dat_rd_pos[0]};
        tokCnt  <= tokCnt + 3'd1;
      end

      rx_valid <= (state == R_DATA) && (stateNxt != IDLE);
      if (state == R_DATA) rx_data <= {dat_rd_pos, dat_rd_neg};
    end
  end

  // NOTE: the CRC register array is reset like any other state; it is small and must never start as X.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int j = 0; j < W; j++) begin
        crcPos[j] <= '0;
        crcNeg[j] <= '0;
      end
      crcErr <= 1'b0;
    end else if (startAcc) begin
      for (int j = 0; j < W; j++) begin
        crcPos[j] <= '0;
        crcNeg[j] <= '0;
      end
      crcErr <= 1'b0;
    end else if (state == W_DATA && tx_valid) begin
      for (int j = 0; j < W; j++) begin
        crcPos[j] <= crcStep(crcPos[j], tx_data[W+j]);
        crcNeg[j] <= crcStep(crcNeg[j], tx_data[j]);
      end
    end else if (state == R_DATA) begin
      for (int j = 0; j < W; j++) begin
        crcPos[j] <= crcStep(crcPos[j], dat_rd_pos[j]);
        crcNeg[j] <= crcStep(crcNeg[j], dat_rd_neg[j]);
      end
    end else if (state == R_CRC && crcMiss) begin
      crcErr <= 1'b1;
    end
  end

  always_comb begin
    crcMiss = 1'b0;
    for (int j = 0; j < W; j++) begin
      if (dat_rd_pos[j] != crcPos[j][crcIdx] || dat_rd_neg[j] != crcNeg[j][crcIdx]) crcMiss = 1'b1;
    end
  end

  // pin drive is decoded from state so reset and abort release the bus without an extra register stage
  always_comb begin
    dat_oe     = 1'b0;
    dat_wr_pos = '1;
    dat_wr_neg = '1;
    case (state)
      W_START: begin
        dat_oe     = 1'b1;
        dat_wr_pos = '0;
        dat_wr_neg = '0;
      end
      W_DATA: begin
        dat_oe     = 1'b1;
        dat_wr_pos = tx_data[2*W-1:W];
        dat_wr_neg = tx_data[W-1:0];
      end
      W_CRC: begin
        dat_oe = 1'b1;
        for (int j = 0; j < W; j++) begin
          dat_wr_pos[j] = crcPos[j][crcIdx];
          dat_wr_neg[j] = crcNeg[j][crcIdx];
        end
      end
      W_END:   dat_oe = 1'b1;
      default: dat_oe = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_emmc_ddr_dat_sequencer.sv
// Scoreboard bench for emmc_ddr_dat_sequencer: write framing, read capture and CRC check,
// token/busy handling, timeouts, underrun, abort and mid-operation reset.
module tb_emmc_ddr_dat_sequencer;

  localparam int W           = 4;
  localparam int BLOCK_BYTES = 8;
  localparam int TOUT_W      = 24;
  localparam int DCYC        = BLOCK_BYTES * 8 / (2 * W);

  typedef struct packed {
    logic         oe;
    logic [W-1:0] pos;
    logic [W-1:0] neg;
  } pins_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              wr_start = 1'b0, rd_start = 1'b0, abort = 1'b0;
  logic [TOUT_W-1:0] rd_tout = TOUT_W'(1000), busy_tout = TOUT_W'(1000);
  logic              seq_busy, done, tx_ready, rx_valid, dat_oe;
  logic [2:0]        status;
  logic [2*W-1:0]    tx_data = '0, rx_data;
  logic              tx_valid = 1'b0;
  logic [W-1:0]      dat_wr_pos, dat_wr_neg;
  logic [W-1:0]      dat_rd_pos = '1, dat_rd_neg = '1;

  pins_t          pinQ[$];
  logic [2*W-1:0] rxQ[$];
  logic [2:0]     statusQ[$];
  logic [2*W-1:0] rxExp;
  logic [2:0]     stExp;
  int             nChecks = 0;
  int             nFail = 0;

  emmc_ddr_dat_sequencer #(.W(W), .BLOCK_BYTES(BLOCK_BYTES), .TOUT_W(TOUT_W)) dut (
    .Clk(Clk), .Reset(Reset), .wr_start(wr_start), .rd_start(rd_start), .abort(abort),
    .rd_tout(rd_tout), .busy_tout(busy_tout), .seq_busy(seq_busy), .done(done), .status(status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .dat_wr_pos(dat_wr_pos), .dat_wr_neg(dat_wr_neg), .dat_oe(dat_oe),
    .dat_rd_pos(dat_rd_pos), .dat_rd_neg(dat_rd_neg)
  );

  always #5 Clk = ~Clk;

  // scoreboard monitor: every rx beat and every done pulse is matched against what the stimulus queued
  always @(negedge Clk) begin
    if (Reset === 1'b1 && rx_valid === 1'b1) begin
      nChecks++;
      if (rxQ.size() == 0) begin
        nFail++;
        $display("FAIL rx_beat: got unexpected beat %h, expected none", rx_data);
      end else begin
        rxExp = rxQ.pop_front();
        if (rx_data !== rxExp) begin
          nFail++;
          $display("FAIL rx_beat: got %h, expected %h", rx_data, rxExp);
        end
      end
    end
    if (Reset === 1'b1 && done === 1'b1) begin
      nChecks++;
      if (statusQ.size() == 0) begin
        nFail++;
        $display("FAIL done_status: got unexpected done (status %0d), expected no done", status);
      end else begin
        stExp = statusQ.pop_front();
        if (status !== stExp) begin
          nFail++;
          $display("FAIL done_status: got %0d, expected %0d", status, stExp);
        end
      end
    end
  end

  function automatic logic [15:0] crcUpd(input logic [15:0] c, input logic b);
    crcUpd = (c << 1) ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // busyCyc < 0: card never answers after the end bit
  task automatic do_write(input logic [DCYC-1:0][2*W-1:0] words, input int dropAt, input int abortAt,
                          input logic [2:0] token, input int busyCyc, input bit withRd,
                          input logic [2:0] expStatus, input int expDoneN);
    logic [15:0] cp[W];
    logic [15:0] cn[W];
    pins_t       p;
    logic        seq[$];
    bit          early;
    int          n;
    for (int j = 0; j < W; j++) begin cp[j] = '0; cn[j] = '0; end
    pinQ.delete();
    p = {1'b1, {W{1'b0}}, {W{1'b0}}};
    pinQ.push_back(p);
    for (int k = 0; k < DCYC; k++) begin
      p = {1'b1, words[k]};
      pinQ.push_back(p);
      for (int j = 0; j < W; j++) begin
        cp[j] = crcUpd(cp[j], words[k][W+j]);
        cn[j] = crcUpd(cn[j], words[k][j]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      p.oe = 1'b1;
      for (int j = 0; j < W; j++) begin
        p.pos[j] = cp[j][15-i];
        p.neg[j] = cn[j][15-i];
      end
      pinQ.push_back(p);
    end
    p = {1'b1, {W{1'b1}}, {W{1'b1}}};
    pinQ.push_back(p);
    statusQ.push_back(expStatus);

    wr_start = 1'b1;
    rd_start = withRd;
    next_cycle();
    wr_start = 1'b0;
    rd_start = 1'b0;
    early = 1'b0;
    for (int c = 0; c < DCYC + 18; c++) begin
      if (c >= 1 && c <= DCYC) begin
        tx_data  = words[c-1];
        tx_valid = !(dropAt >= 0 && c - 1 == dropAt);
      end else begin
        tx_data  = '0;
        tx_valid = 1'b0;
      end
      abort = (abortAt >= 0 && c == abortAt);
      @(negedge Clk);
      p = pinQ.pop_front();
      nChecks++;
      if ({dat_oe, dat_wr_pos, dat_wr_neg} !== p) begin
        nFail++;
        $display("FAIL wr_pins c%0d: got oe=%b pos=%h neg=%h, expected oe=%b pos=%h neg=%h",
                 c, dat_oe, dat_wr_pos, dat_wr_neg, p.oe, p.pos, p.neg);
      end
      if (c >= 1 && c <= DCYC) begin
        nChecks++;
        if (tx_ready !== tx_valid) begin
          nFail++;
          $display("FAIL tx_ready c%0d: got %b, expected %b", c, tx_ready, tx_valid);
        end
      end
      next_cycle();
      if ((dropAt >= 0 && c == dropAt + 1) || (abortAt >= 0 && c == abortAt)) begin
        early = 1'b1;
        break;
      end
    end
    abort    = 1'b0;
    tx_valid = 1'b0;

    if (early) begin
      @(negedge Clk);
      nChecks++;
      if (dat_oe !== 1'b0 || dat_wr_pos !== '1 || dat_wr_neg !== '1 || done !== 1'b1) begin
        nFail++;
        $display("FAIL wr_stop: got oe=%b pos=%h neg=%h done=%b, expected oe=0 pos=f neg=f done=1",
                 dat_oe, dat_wr_pos, dat_wr_neg, done);
      end
    end else begin
      if (busyCyc >= 0) begin
        seq = '{1'b1, 1'b1, 1'b0, token[2], token[1], token[0], 1'b1};
        for (int i = 0; i < busyCyc; i++) seq.push_back(1'b0);
      end
      n = 0;
      forever begin
        dat_rd_pos    = '1;
        dat_rd_pos[0] = (n < seq.size()) ? seq[n] : 1'b1;
        @(negedge Clk);
        if (n == 0) begin
          nChecks++;
          if (dat_oe !== 1'b0) begin
            nFail++;
            $display("FAIL wr_oe_release: got %b, expected 0", dat_oe);
          end
        end
        if (done === 1'b1) break;
        if (n >= 200) begin
          nChecks++;
          nFail++;
          $display("FAIL wr_done_wait: got no done in %0d cycles, expected done", n);
          break;
        end
        next_cycle();
        n++;
      end
      if (expDoneN >= 0) begin
        nChecks++;
        if (n !== expDoneN) begin
          nFail++;
          $display("FAIL wr_done_cycle: got %0d, expected %0d", n, expDoneN);
        end
      end
    end
    next_cycle();
    dat_rd_pos = '1;
    @(negedge Clk);
    nChecks++;
    if (done !== 1'b0 || seq_busy !== 1'b0 || status !== expStatus) begin
      nFail++;
      $display("FAIL wr_after: got done=%b busy=%b status=%0d, expected done=0 busy=0 status=%0d",
               done, seq_busy, status, expStatus);
    end
    next_cycle();
  endtask

  // resetAt >= 0: reset is pulsed during that data cycle and the task returns
  task automatic do_read(input logic [DCYC-1:0][2*W-1:0] words, input int startDelay, input int flipAt,
                         input logic [W-1:0] endVal, input logic [2:0] expStatus, input int resetAt);
    logic [15:0] cp[W];
    logic [15:0] cn[W];
    for (int j = 0; j < W; j++) begin cp[j] = '0; cn[j] = '0; end
    rxQ.delete();
    if (resetAt < 0) statusQ.push_back(expStatus);
    dat_rd_pos = '1;
    dat_rd_neg = '1;
    rd_start = 1'b1;
    next_cycle();
    rd_start = 1'b0;
    for (int d = 0; d < startDelay; d++) next_cycle();
    dat_rd_pos = '0;
    dat_rd_neg = '0;
    next_cycle();
    for (int k = 0; k < DCYC; k++) begin
      dat_rd_pos = words[k][2*W-1:W];
      dat_rd_neg = words[k][W-1:0];
      rxQ.push_back(words[k]);
      for (int j = 0; j < W; j++) begin
        cp[j] = crcUpd(cp[j], words[k][W+j]);
        cn[j] = crcUpd(cn[j], words[k][j]);
      end
      if (k == resetAt) begin
        #2;
        Reset = 1'b0;
        #1;
        nChecks++;
        if (dat_oe !== 1'b0 || dat_wr_pos !== '1 || dat_wr_neg !== '1 || rx_valid !== 1'b0 ||
            rx_data !== '0 || seq_busy !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin
          nFail++;
          $display("FAIL reset_mid_read: got oe=%b pos=%h neg=%h rxv=%b rxd=%h busy=%b done=%b st=%0d, expected 0 f f 0 00 0 0 0",
                   dat_oe, dat_wr_pos, dat_wr_neg, rx_valid, rx_data, seq_busy, done, status);
        end
        rxQ.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset      = 1'b1;
        dat_rd_pos = '1;
        dat_rd_neg = '1;
        next_cycle();
        @(negedge Clk);
        nChecks++;
        if (done !== 1'b0 || seq_busy !== 1'b0) begin
          nFail++;
          $display("FAIL reset_release: got done=%b busy=%b, expected 0 0", done, seq_busy);
        end
        next_cycle();
        return;
      end
      @(negedge Clk);
      if (k <= 1) begin
        nChecks++;
        if (rx_valid !== (k == 1)) begin
          nFail++;
          $display("FAIL rd_latency k%0d: got rx_valid=%b, expected %b", k, rx_valid, (k == 1));
        end
      end
      next_cycle();
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < W; j++) begin
        dat_rd_pos[j] = cp[j][15-i];
        dat_rd_neg[j] = cn[j][15-i];
      end
      if (i == flipAt) dat_rd_pos[0] = ~dat_rd_pos[0];
      next_cycle();
    end
    dat_rd_pos = endVal;
    dat_rd_neg = '1;
    next_cycle();
    dat_rd_pos = '1;
    @(negedge Clk);
    nChecks++;
    if (done !== 1'b1) begin
      nFail++;
      $display("FAIL rd_done: got %b, expected 1", done);
    end
    next_cycle();
    @(negedge Clk);
    nChecks++;
    if (rxQ.size() != 0 || done !== 1'b0) begin
      nFail++;
      $display("FAIL rd_after: got %0d beats missing done=%b, expected 0 missing done=0", rxQ.size(), done);
    end
    next_cycle();
  endtask

  task automatic do_read_timeout(input logic [TOUT_W-1:0] tout, input int expN);
    int n;
    rd_tout = tout;
    statusQ.push_back(3'd3);
    dat_rd_pos = '1;
    rd_start = 1'b1;
    next_cycle();
    rd_start = 1'b0;
    n = 0;
    forever begin
      @(negedge Clk);
      if (done === 1'b1) break;
      if (n >= 400) begin
        nChecks++;
        nFail++;
        $display("FAIL rd_timeout_wait: got no done in %0d cycles, expected done", n);
        break;
      end
      next_cycle();
      n++;
    end
    nChecks++;
    if (n !== expN) begin
      nFail++;
      $display("FAIL rd_timeout_cycle: got %0d, expected %0d", n, expN);
    end
    next_cycle();
    rd_tout = TOUT_W'(1000);
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #1;
    nChecks++;
    if (dat_oe !== 1'b0 || dat_wr_pos !== '1 || dat_wr_neg !== '1 || tx_ready !== 1'b0 ||
        rx_valid !== 1'b0 || rx_data !== '0 || seq_busy !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin
      nFail++;
      $display("FAIL reset_values: got oe=%b pos=%h neg=%h rdy=%b rxv=%b rxd=%h busy=%b done=%b st=%0d, expected 0 f f 0 0 00 0 0 0",
               dat_oe, dat_wr_pos, dat_wr_neg, tx_ready, rx_valid, rx_data, seq_busy, done, status);
    end
    @(negedge Clk);
    Reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_write();
    logic [DCYC-1:0][2*W-1:0] w;
    w = '0;
    do_write(w, -1, -1, 3'b010, 5, 1'b0, 3'd0, 13);
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_write(w, -1, -1, 3'b010, 2, 1'b0, 3'd0, 10);
  endtask

  task automatic test_read();
    logic [DCYC-1:0][2*W-1:0] w;
    for (int k = 0; k < DCYC; k++) w[k] = 8'(k);
    do_read(w, 10, -1, 4'hF, 3'd0, -1);
    do_read(w, 10, 6, 4'hF, 3'd1, -1);
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_read(w, 0, -1, 4'h7, 3'd2, -1);
  endtask

  task automatic test_underrun();
    logic [DCYC-1:0][2*W-1:0] w;
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_write(w, 3, -1, 3'b010, 0, 1'b0, 3'd5, -1);
  endtask

  task automatic test_timeouts();
    logic [DCYC-1:0][2*W-1:0] w;
    do_read_timeout(TOUT_W'(100), 100);
    do_read_timeout(TOUT_W'(0), 1);
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_write(w, -1, -1, 3'b101, 0, 1'b0, 3'd4, 7);
    busy_tout = TOUT_W'(3);
    do_write(w, -1, -1, 3'b010, -1, 1'b0, 3'd3, 3);
    busy_tout = TOUT_W'(0);
    do_write(w, -1, -1, 3'b010, -1, 1'b0, 3'd3, 1);
    busy_tout = TOUT_W'(1000);
  endtask

  task automatic test_abort();
    logic [DCYC-1:0][2*W-1:0] w;
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_write(w, -1, DCYC + 6, 3'b010, 0, 1'b0, 3'd6, -1);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      nChecks++;
      if (done !== 1'b0 || seq_busy !== 1'b0) begin
        nFail++;
        $display("FAIL abort_idle: got done=%b busy=%b, expected 0 0", done, seq_busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [DCYC-1:0][2*W-1:0] w;
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_write(w, -1, -1, 3'b010, 1, 1'b1, 3'd0, 9);
    do_read(w, 2, -1, 4'hF, 3'd0, -1);
  endtask

  task automatic test_reset_mid_read();
    logic [DCYC-1:0][2*W-1:0] w;
    for (int k = 0; k < DCYC; k++) w[k] = 8'($urandom);
    do_read(w, 3, -1, 4'hF, 3'd0, 3);
    do_read(w, 4, -1, 4'hF, 3'd0, -1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_underrun();
    test_timeouts();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    nChecks++;
    if (statusQ.size() != 0) begin
      nFail++;
      $display("FAIL status_drain: got %0d pending results, expected 0", statusQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
